// File: rtl/ptp_tsu_pkg.sv
// ptp_tsu_pkg: shared constants, record layout and parser state type for the
// PTP timestamp unit. Byte offsets are counted from the first DA byte.
package ptp_tsu_pkg;

    localparam logic [15:0] ETH_PTP       = 16'h88F7;
    localparam logic [15:0] ETH_VLAN      = 16'h8100;
    localparam logic [15:0] ETH_IPV4      = 16'h0800;
    localparam logic [15:0] UDP_PTP_EVENT = 16'd319;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [7:0]  IPV4_VIHL     = 8'h45;   // version 4, IHL 5
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    // Frame offsets (untagged); a VLAN tag shifts all of them by VLAN_TAG_LEN.
    localparam logic [7:0]  OFS_ETH       = 8'd12;
    localparam logic [7:0]  OFS_VIHL      = 8'd14;
    localparam logic [7:0]  OFS_PROTO     = 8'd23;
    localparam logic [7:0]  OFS_DPORT     = 8'd36;
    localparam logic [7:0]  VLAN_TAG_LEN  = 8'd4;
    localparam logic [7:0]  P_L2          = 8'd14;
    localparam logic [7:0]  P_UDP         = 8'd42;
    localparam logic [7:0]  SEQ_OFS       = 8'd30;

    // Record layout: [63:60] msgType, [59:44] seqId, [43:32] sec[11:0], [31:0] ns
    localparam int REC_W       = 64;
    localparam int REC_MT_LSB  = 60;
    localparam int REC_SEQ_LSB = 44;
    localparam int REC_SEC_LSB = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAME,
        ST_DONE
    } state_t;

    // ts holds rtc[43:0]: sec[11:0] above ns[31:0], which is exactly the
    // low 44 bits of the record.
    function automatic logic [REC_W-1:0] pack_rec(input logic [3:0]  mt,
                                                  input logic [15:0] seq,
                                                  input logic [43:0] ts);
        logic [REC_W-1:0] r;
        r                        = '0;
        r[REC_MT_LSB  +: 4]      = mt;
        r[REC_SEQ_LSB +: 16]     = seq;
        r[REC_SEC_LSB +: 12]     = ts[43:32];
        r[31:0]                  = ts[31:0];
        return r;
    endfunction

endpackage

// File: rtl/ptp_tsu_if.sv
// ptp_tsu_if: GMII snoop inputs, RTC time and host queue read port.
//   gmii_ctrl/gmii_data : snooped GMII byte stream
//   rtc_timer_in        : {seconds[47:0], nanoseconds[31:0]}
//   q_rd_en             : host pop request
//   q_rd_stat/q_rd_data : queue occupancy and FWFT head entry
interface ptp_tsu_if;
    logic        gmii_ctrl;
    logic [7:0]  gmii_data;
    logic [79:0] rtc_timer_in;
    logic        q_rd_en;
    logic [7:0]  q_rd_stat;
    logic [63:0] q_rd_data;

    modport slave (
        input  gmii_ctrl, gmii_data, rtc_timer_in, q_rd_en,
        output q_rd_stat, q_rd_data
    );

    modport master (
        output gmii_ctrl, gmii_data, rtc_timer_in, q_rd_en,
        input  q_rd_stat, q_rd_data
    );
endinterface

// File: rtl/ptp_tsu_fifo.sv
// ptp_tsu_fifo: synchronous first-word-fall-through FIFO with occupancy count.
//   i_wr_en/i_wr_data : push (dropped when full unless a pop happens too)
//   i_rd_en           : pop (ignored when empty)
//   o_count           : entries held, 0..DEPTH
//   o_rd_data         : registered head entry
module ptp_tsu_fifo
    import ptp_tsu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = REC_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [7:0]   o_count,
    output logic [W-1:0] o_rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]    r_count;
    logic [W-1:0]  r_head;
    logic          w_pop, w_push;
    logic [AW-1:0] w_wr_nxt, w_rd_nxt;

    assign w_pop    = i_rd_en && (r_count != 8'd0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push   = i_wr_en && ((r_count != 8'(DEPTH)) || w_pop);
    assign w_wr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            r_count <= r_count + 8'(w_push) - 8'(w_pop);
            // Head register tracks the entry at the next read pointer; the
            // incoming word bypasses memory when it becomes the head directly.
            if (w_pop) begin
                if (r_count > 8'd1)  r_head <= r_mem[w_rd_nxt];
                else if (w_push)     r_head <= i_wr_data;
            end else if (w_push && (r_count == 8'd0)) begin
                r_head <= i_wr_data;
            end
        end
    end

    assign o_count   = r_count;
    assign o_rd_data = r_head;
endmodule

// File: rtl/ptp_tsu.sv
// ptp_tsu: GMII PTP timestamp unit. Latches the RTC on SFD, classifies the
// frame (L2 / VLAN / IPv4-UDP port 319) and queues a record for each PTP
// event message (messageType 0..3) when the frame ends.
//   gmii_clk : single clock
//   rst      : synchronous active-high reset (parser idle, queue flushed)
//   bus      : ptp_tsu_if.slave (GMII snoop, RTC, queue read port)
module ptp_tsu
    import ptp_tsu_pkg::*;
#(
    parameter int Q_DEPTH = 16
) (
    input  logic      gmii_clk,
    input  logic      rst,
    ptp_tsu_if.slave  bus
);
    state_t      r_state, w_nxt;
    logic        w_sfd, w_byte, w_push, w_qual;
    logic [43:0] r_ts;
    logic [7:0]  r_cnt, r_hi, w_ofs, w_p;
    logic        r_vlan, r_l2, r_ip, r_ihl_ok, r_udp_ok, r_port_ok, r_got_seq;
    logic [3:0]  r_mtype;
    logic [15:0] r_seq;
    logic [7:0]  w_count;
    logic [63:0] w_head;
    logic        w_unused;

    // Only sec[11:0] and ns reach the record.
    assign w_unused = ^bus.rtc_timer_in[79:44];

    // ---------------- parser FSM ----------------
    always_ff @(posedge gmii_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            // DONE lasts one cycle; a following frame may already start in it.
            ST_IDLE, ST_DONE:
                if (bus.gmii_ctrl) w_nxt = (bus.gmii_data == SFD) ? ST_FRAME : ST_PREAMBLE;
                else               w_nxt = ST_IDLE;
            ST_PREAMBLE:
                if (!bus.gmii_ctrl)              w_nxt = ST_IDLE;
                else if (bus.gmii_data == SFD)   w_nxt = ST_FRAME;
            ST_FRAME:
                if (!bus.gmii_ctrl) w_nxt = ST_DONE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sfd  = (r_state != ST_FRAME) && bus.gmii_ctrl && (bus.gmii_data == SFD);
        w_byte = (r_state == ST_FRAME) && bus.gmii_ctrl;
        w_push = (r_state == ST_FRAME) && !bus.gmii_ctrl && w_qual;
    end

    // ---------------- classifier ----------------
    assign w_ofs  = r_vlan ? VLAN_TAG_LEN : 8'd0;
    assign w_p    = (r_l2 ? P_L2 : P_UDP) + w_ofs;
    assign w_qual = r_got_seq && (r_mtype[3:2] == 2'b00) &&
                    (r_l2 || (r_ip && r_ihl_ok && r_udp_ok && r_port_ok));

    always_ff @(posedge gmii_clk) begin
        if (rst || w_sfd) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_vlan    <= 1'b0;
            r_l2      <= 1'b0;
            r_ip      <= 1'b0;
            r_ihl_ok  <= 1'b0;
            r_udp_ok  <= 1'b0;
            r_port_ok <= 1'b0;
            r_got_seq <= 1'b0;
            r_mtype   <= '0;
            r_seq     <= '0;
            r_ts      <= rst ? 44'd0 : bus.rtc_timer_in[43:0];
        end else if (w_byte) begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (r_cnt == OFS_ETH + w_ofs) r_hi <= bus.gmii_data;
            // Ethertype check runs at 12-13, and again at 16-17 once tagged;
            // a second VLAN tag matches neither PTP nor IPv4.
            if (r_cnt == OFS_ETH + w_ofs + 8'd1) begin
                if ({r_hi, bus.gmii_data} == ETH_VLAN) r_vlan <= 1'b1;
                if ({r_hi, bus.gmii_data} == ETH_PTP)  r_l2   <= 1'b1;
                if ({r_hi, bus.gmii_data} == ETH_IPV4) r_ip   <= 1'b1;
            end
            if (r_cnt == OFS_VIHL + w_ofs)  r_ihl_ok <= (bus.gmii_data == IPV4_VIHL);
            if (r_cnt == OFS_PROTO + w_ofs) r_udp_ok <= (bus.gmii_data == IP_PROTO_UDP);
            if (r_cnt == OFS_DPORT + w_ofs) r_hi     <= bus.gmii_data;
            if (r_cnt == OFS_DPORT + w_ofs + 8'd1)
                r_port_ok <= ({r_hi, bus.gmii_data} == UDP_PTP_EVENT);
            if (r_cnt == w_p) r_mtype <= bus.gmii_data[3:0];
            if (r_cnt == w_p + SEQ_OFS) r_seq[15:8] <= bus.gmii_data;
            if (r_cnt == w_p + SEQ_OFS + 8'd1) begin
                r_seq[7:0] <= bus.gmii_data;
                r_got_seq  <= 1'b1;
            end
        end
    end

    // ---------------- record queue ----------------
    ptp_tsu_fifo #(.DEPTH(Q_DEPTH), .W(REC_W)) u_fifo (
        .i_clk     (gmii_clk),
        .i_rst     (rst),
        .i_wr_en   (w_push),
        .i_wr_data (pack_rec(r_mtype, r_seq, r_ts)),
        .i_rd_en   (bus.q_rd_en),
        .o_count   (w_count),
        .o_rd_data (w_head)
    );

    assign bus.q_rd_stat = w_count;
    assign bus.q_rd_data = w_head;
endmodule

// File: tb/tb_ptp_tsu.sv
// tb_ptp_tsu: randomized frames against a byte-array reference classifier;
// expected records are queued when frames are issued and a negedge monitor
// compares occupancy and head entry against that queue.
module tb_ptp_tsu;
    import ptp_tsu_pkg::*;

    localparam int QD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ptp_tsu_if bus();

    ptp_tsu #(.Q_DEPTH(QD)) dut (
        .gmii_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  fr[$];
    bit          pend_push = 0;
    logic [63:0] pend_rec;
    bit          mon_en = 0;
    int          rd_pct = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [79:0] rnd80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    function automatic logic [7:0] rb();
        return 8'($urandom);
    endfunction

    function automatic bit rdr();
        return ($urandom % 100) < rd_pct;
    endfunction

    // Reference classifier working directly on the frame bytes.
    function automatic bit model(input logic [79:0] ts, output logic [63:0] rec);
        int n, b, p;
        logic [15:0] et;
        rec = '0;
        n = fr.size();
        b = 0;
        p = -1;
        if (n < 14) return 0;
        et = {fr[12], fr[13]};
        if (et == 16'h8100) begin
            if (n < 18) return 0;
            et = {fr[16], fr[17]};
            b = 4;
        end
        if (et == 16'h88F7) p = 14 + b;
        else if (et == 16'h0800 && n > 38 + b && fr[14+b] == 8'h45 && fr[23+b] == 8'd17 &&
                 {fr[36+b], fr[37+b]} == 16'd319) p = 42 + b;
        if (p < 0 || n < p + 32) return 0;
        if (fr[p][3:0] > 4'd3) return 0;
        rec = {fr[p][3:0], fr[p+30], fr[p+31], ts[43:32], ts[31:0]};
        return 1;
    endfunction

    // One GMII cycle; the expected queue changes at the same edge as the DUT.
    task automatic cyc(input bit c, input logic [7:0] d, input bit rd, input logic [79:0] rtc);
        bus.gmii_ctrl    = c;
        bus.gmii_data    = d;
        bus.q_rd_en      = rd;
        bus.rtc_timer_in = rtc;
        @(posedge clk);
        if (rst) exp_q.delete();
        else begin
            if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (pend_push && exp_q.size() < QD) exp_q.push_back(pend_rec);
        end
        pend_push = 0;
        #1;
    endtask

    // kind: 0 L2, 1 UDP:319, 2 UDP:320, 3 other ethertype, 4 IHL 6, 5 TCP
    task automatic build(input int kind, input logic [3:0] mt, input logic [15:0] seq,
                         input bit vlan, input int tail);
        fr.delete();
        repeat (12) fr.push_back(rb());
        if (vlan) begin
            fr.push_back(8'h81); fr.push_back(8'h00); fr.push_back(rb()); fr.push_back(rb());
        end
        if (kind == 0) begin
            fr.push_back(8'h88); fr.push_back(8'hF7);
        end else if (kind == 3) begin
            fr.push_back(8'h86); fr.push_back(8'hDD);
        end else begin
            fr.push_back(8'h08); fr.push_back(8'h00);
            fr.push_back((kind == 4) ? 8'h46 : 8'h45);
            repeat (8) fr.push_back(rb());
            fr.push_back((kind == 5) ? 8'd6 : 8'd17);
            repeat (10) fr.push_back(rb());
            repeat (2) fr.push_back(rb());
            fr.push_back(8'h01);
            fr.push_back((kind == 2) ? 8'h40 : 8'h3F);
            repeat (4) fr.push_back(rb());
        end
        fr.push_back({4'($urandom), mt});
        repeat (29) fr.push_back(rb());
        fr.push_back(seq[15:8]);
        fr.push_back(seq[7:0]);
        repeat (tail) fr.push_back(rb());
    endtask

    task automatic send(input logic [79:0] ts, input int gap, input bit rd_end);
        logic [63:0] r;
        bit q;
        repeat (7) cyc(1'b1, 8'h55, rdr(), rnd80());
        cyc(1'b1, SFD, rdr(), ts);
        foreach (fr[i]) cyc(1'b1, fr[i], rdr(), rnd80());
        q = model(ts, r);
        pend_push = q;
        pend_rec  = r;
        cyc(1'b0, rb(), rd_end, rnd80());
        repeat (gap) cyc(1'b0, rb(), rdr(), rnd80());
    endtask

    task automatic drain();
        for (int i = 0; i < QD + 2; i++) cyc(1'b0, 8'h00, 1'b1, rnd80());
    endtask

    // Monitor: occupancy every cycle, head whenever something is queued.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check64("q_rd_stat", 64'(bus.q_rd_stat), 64'(exp_q.size()));
                if (exp_q.size() > 0) check64("q_rd_data", bus.q_rd_data, exp_q[0]);
            end
        end
    end

    initial begin
        logic [79:0] ts;
        logic [15:0] sq;
        int k, n;
        rst = 1'b1;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 80'd0);
        rst = 1'b0;
        @(negedge clk);
        check64("reset_data", bus.q_rd_data, 64'd0);
        check64("reset_stat", 64'(bus.q_rd_stat), 64'd0);
        mon_en = 1;

        // L2 Sync with known timestamp (upper seconds bits must be discarded)
        build(0, 4'd0, 16'h0102, 0, 4);
        fr[14] = 8'h00;
        ts = {36'hABCDEF012, 12'h064, 32'h0000_1234};
        send(ts, 2, 0);
        @(negedge clk);
        check64("sync_stat", 64'(bus.q_rd_stat), 64'd1);
        check64("sync_rec", bus.q_rd_data, 64'h0010_2064_0000_1234);
        drain();

        // UDP Delay_Req to 319, then the same to 320 (not queued)
        build(1, 4'd1, 16'hBEEF, 0, 0);
        send(rnd80(), 1, 0);
        @(negedge clk);
        check64("udp_hi", 64'(bus.q_rd_data[63:44]), 64'h1BEEF);
        build(2, 4'd1, 16'hBEEF, 0, 0);
        send(rnd80(), 1, 0);
        @(negedge clk);
        check64("udp320_stat", 64'(bus.q_rd_stat), 64'd1);
        drain();

        // VLAN Pdelay_Req queued; VLAN Follow_Up not
        sq = 16'($urandom);
        build(0, 4'd2, sq, 1, 2);
        send(rnd80(), 1, 0);
        @(negedge clk);
        check64("vlan_seq", 64'(bus.q_rd_data[59:44]), 64'({fr[48], fr[49]}));
        check64("vlan_mt", 64'(bus.q_rd_data[63:60]), 64'd2);
        build(0, 4'd8, 16'($urandom), 1, 2);
        send(rnd80(), 1, 0);
        @(negedge clk);
        check64("followup_stat", 64'(bus.q_rd_stat), 64'd1);
        drain();

        // Overflow: 17 frames, no reads; back-to-back with one idle cycle
        rd_pct = 0;
        for (int i = 0; i < QD + 1; i++) begin
            build(i % 2, 4'(i % 4), 16'(i * 257 + 3), 0, 0);
            send(rnd80(), 0, 0);
        end
        @(negedge clk);
        check64("full_stat", 64'(bus.q_rd_stat), 64'(QD));
        // Push while full with a simultaneous pop is accepted
        build(0, 4'd3, 16'h7777, 0, 0);
        send(rnd80(), 0, 1);
        @(negedge clk);
        check64("full_pushpop", 64'(bus.q_rd_stat), 64'(QD));
        drain();

        // Push and pop together at count 3, then pop on empty
        for (int i = 0; i < 3; i++) begin
            build(0, 4'd0, 16'(i), 0, 0);
            send(rnd80(), 0, 0);
        end
        build(1, 4'd3, 16'hCAFE, 0, 0);
        send(rnd80(), 0, 1);
        @(negedge clk);
        check64("pushpop3", 64'(bus.q_rd_stat), 64'd3);
        drain();
        cyc(1'b0, 8'h00, 1'b1, rnd80());
        @(negedge clk);
        check64("pop_empty", 64'(bus.q_rd_stat), 64'd0);

        // Reset at byte 20 of a PTP frame with records already queued
        for (int i = 0; i < 2; i++) begin
            build(0, 4'd1, 16'(i), 0, 0);
            send(rnd80(), 0, 0);
        end
        build(0, 4'd0, 16'h5A5A, 0, 0);
        repeat (7) cyc(1'b1, 8'h55, 1'b0, rnd80());
        cyc(1'b1, SFD, 1'b0, rnd80());
        for (int i = 0; i < 20; i++) cyc(1'b1, fr[i], 1'b0, rnd80());
        rst = 1'b1;
        cyc(1'b1, fr[20], 1'b0, rnd80());
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, rnd80());
        @(negedge clk);
        check64("midrst_stat", 64'(bus.q_rd_stat), 64'd0);
        build(0, 4'd0, 16'h1357, 0, 0);
        send(rnd80(), 1, 0);
        @(negedge clk);
        check64("after_rst_stat", 64'(bus.q_rd_stat), 64'd1);

        // Preamble with no SFD, then a frame right behind it
        repeat (5) cyc(1'b1, 8'h55, 1'b0, rnd80());
        cyc(1'b0, 8'h00, 1'b0, rnd80());
        build(1, 4'd2, 16'h2468, 0, 0);
        send(rnd80(), 0, 0);
        drain();

        // Long frame exercising the saturating byte counter
        build(0, 4'd1, 16'h9999, 0, 250);
        send(rnd80(), 1, 0);
        drain();

        // Random mix with random host reads
        rd_pct = 30;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(5, 0);
            build(k, ($urandom_range(1, 0) != 0) ? 4'($urandom_range(3, 0)) : 4'($urandom),
                  16'($urandom), $urandom_range(1, 0) != 0, $urandom_range(6, 0));
            if ($urandom_range(5, 0) == 0) begin
                n = $urandom_range(fr.size() - 1, 10);
                while (fr.size() > n) void'(fr.pop_back());
            end
            send(rnd80(), $urandom_range(3, 0), $urandom_range(1, 0) != 0);
        end
        rd_pct = 0;
        drain();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
